data_mem_ctrl: RTL and testbench

//  Load/store unit between the mips core's memory-stage request and the data_ram byte-write port.

---
 rtl/data_mem_ctrl.sv | 147 ++++++++++++++
 tb/tb_data_mem_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit between the core memory stage and a
// byte-write data RAM with a configurable read latency.
module data_mem_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              addr_err,
    output logic [31:0]       err_addr,
    output logic              ram_ena,
    output logic [3:0]        ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [31:0]       ram_dina,
    input  logic [31:0]       ram_douta
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [1:0]  cnt;
    logic        accept;
    logic        illegal;
    logic [3:0]  wmask;
    logic [31:0] wrep;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    logic [31:0] ld_ext;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Store lane mask, replicated store data and alignment check.
    always_comb begin
        illegal = 1'b0;
        wmask   = 4'b0000;
        wrep    = req_wdata;
        unique case (req_size)
            2'd0: begin
                wmask = 4'b0001 << req_addr[1:0];
                wrep  = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                illegal = req_addr[0];
                wmask   = 4'b0011 << {req_addr[1], 1'b0};
                wrep    = {2{req_wdata[15:0]}};
            end
            2'd2: begin
                illegal = |req_addr[1:0];
                wmask   = 4'b1111;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        ld_b   = 8'(ram_douta >> {off_q, 3'b000});
        ld_h   = off_q[1] ? ram_douta[31:16] : ram_douta[15:0];
        ld_ext = ram_douta;
        unique case (1'b1)
            size_q == 2'd0: ld_ext = {{24{ld_b[7] & ~uns_q}}, ld_b};
            size_q == 2'd1: ld_ext = {{16{ld_h[15] & ~uns_q}}, ld_h};
            default:        ld_ext = ram_douta;
        endcase
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= 2'd0;
            cnt        <= 2'd0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            addr_err   <= 1'b0;
            err_addr   <= '0;
            ram_ena    <= 1'b0;
            ram_wea    <= 4'b0000;
            ram_addra  <= '0;
            ram_dina   <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            addr_err   <= 1'b0;
            ram_ena    <= 1'b0;
            ram_wea    <= 4'b0000;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        we_q   <= req_we;
                        uns_q  <= req_unsigned;
                        size_q <= req_size;
                        off_q  <= req_addr[1:0];
                        if (illegal) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            addr_err   <= 1'b1;
                            err_addr   <= req_addr;
                        end else begin
                            state     <= ISSUE;
                            ram_ena   <= 1'b1;
                            ram_wea   <= req_we ? wmask : 4'b0000;
                            ram_addra <= {req_addr[ADDR_W-1:2], 2'b00};
                            ram_dina  <= wrep;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        state <= WAIT;
                        cnt   <= 2'(RD_LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= ld_ext;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl at read latencies 1 and 3, against a
// byte-addressed memory model and per-access expected responses.
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    logic clka = 1'b0;
    always #5 clka = ~clka;

    logic        rst          [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_we       [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] req_addr     [2];
    logic [31:0] req_wdata    [2];
    logic        resp_valid   [2];
    logic [31:0] resp_rdata   [2];
    logic        addr_err     [2];
    logic [31:0] err_addr     [2];
    logic        ram_ena      [2];
    logic [3:0]  ram_wea      [2];
    logic [31:0] ram_addra    [2];
    logic [31:0] ram_dina     [2];
    logic [31:0] ram_douta    [2];

    bit [31:0] mem  [2][64];
    bit [31:0] pipe [2][3];
    bit [7:0]  gm   [2][256];
    int lat       [2] = '{1, 3};
    int resp_seen [2] = '{0, 0};
    int resp_exp  [2] = '{0, 0};
    int n_chk  = 0;
    int n_pass = 0;

    data_mem_ctrl #(.ADDR_W(32), .RD_LATENCY(1)) u_l1 (
        .clka(clka), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .addr_err(addr_err[0]),
        .err_addr(err_addr[0]), .ram_ena(ram_ena[0]),
        .ram_wea(ram_wea[0]), .ram_addra(ram_addra[0]),
        .ram_dina(ram_dina[0]), .ram_douta(ram_douta[0])
    );

    data_mem_ctrl #(.ADDR_W(32), .RD_LATENCY(3)) u_l3 (
        .clka(clka), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .addr_err(addr_err[1]),
        .err_addr(err_addr[1]), .ram_ena(ram_ena[1]),
        .ram_wea(ram_wea[1]), .ram_addra(ram_addra[1]),
        .ram_dina(ram_dina[1]), .ram_douta(ram_douta[1])
    );

    assign ram_douta[0] = pipe[0][0];
    assign ram_douta[1] = pipe[1][2];

    // Byte-write RAMs with 1- and 3-cycle read pipelines.
    always @(posedge clka) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_ena[d]) begin
                for (int k = 0; k < 4; k++)
                    if (ram_wea[d][k])
                        mem[d][ram_addra[d][7:2]][8*k +: 8] <= ram_dina[d][8*k +: 8];
                pipe[d][0] <= mem[d][ram_addra[d][7:2]];
            end
            pipe[d][1] <= pipe[d][0];
            pipe[d][2] <= pipe[d][1];
            if (resp_valid[d]) resp_seen[d] <= resp_seen[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic void model(input int d, input bit we, input bit [1:0] sz,
                                  input bit uns, input bit [31:0] a, input bit [31:0] wd,
                                  output bit err, output bit [31:0] rd,
                                  output bit [3:0] wea, output bit [31:0] dina);
        int nb;
        longint v;
        nb   = 1 << sz;
        err  = (sz == 2'd3) || (a % nb != 0);
        rd   = 0;
        wea  = 0;
        dina = 0;
        v    = 0;
        if (err) return;
        for (int k = 0; k < 4; k++) dina[8*k +: 8] = wd[8*(k % nb) +: 8];
        if (we) begin
            wea = 4'(((1 << nb) - 1) << a[1:0]);
            for (int i = 0; i < nb; i++) gm[d][a + i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nb; i++) v += longint'(gm[d][a + i]) << (8*i);
            if (!uns && nb < 4 && v[8*nb-1]) v -= longint'(1) << (8*nb);
            rd = v[31:0];
        end
    endfunction

    // One access with req_valid left high afterwards; returns at the response cycle.
    task automatic xact(input int d, input bit we, input bit [1:0] sz, input bit uns,
                        input bit [31:0] a, input bit [31:0] wd, output bit [31:0] got);
        bit        e_err;
        bit [31:0] e_rd;
        bit [31:0] e_dina;
        bit [3:0]  e_wea;
        int w = 0, e_lat, ena_cnt = 0, ena_at = 0, rn = 0, bad = 0;
        req_we[d]       = we;
        req_size[d]     = sz;
        req_unsigned[d] = uns;
        req_addr[d]     = a;
        req_wdata[d]    = wd;
        req_valid[d]    = 1'b1;
        while (!req_ready[d] && w < 20) begin
            @(negedge clka);
            w++;
        end
        chk("accept", 32'(req_ready[d]), 32'd1);
        model(d, we, sz, uns, a, wd, e_err, e_rd, e_wea, e_dina);
        e_lat = e_err ? 1 : (we ? 2 : 2 + lat[d]);
        resp_exp[d]++;
        got = 0;
        for (int n = 1; n <= 8 && rn == 0; n++) begin
            @(negedge clka);
            if (ram_ena[d]) begin
                ena_cnt++;
                ena_at = n;
                chk("wea", 32'(ram_wea[d]), 32'(e_wea));
                chk("addra", ram_addra[d], {a[31:2], 2'b00});
                if (we) chk("dina", ram_dina[d], e_dina);
            end else if (ram_wea[d] != 4'b0000) bad++;
            if (resp_valid[d]) begin
                rn  = n;
                got = resp_rdata[d];
                chk("rdata", resp_rdata[d], e_rd);
                chk("addr_err", 32'(addr_err[d]), 32'(e_err));
                if (e_err) chk("err_addr", err_addr[d], a);
            end else if (resp_rdata[d] != 0 || addr_err[d]) bad++;
        end
        chk("ena_count", 32'(ena_cnt), e_err ? 32'd0 : 32'd1);
        if (!e_err) chk("issue_cycle", 32'(ena_at), 32'd1);
        chk("resp_cycle", 32'(rn), 32'(e_lat));
        chk("idle_outputs", 32'(bad), 32'd0);
    endtask

    task automatic reset_test(input int d);
        int w = 0;
        req_we[d]       = 1'b0;
        req_size[d]     = 2'd2;
        req_unsigned[d] = 1'b0;
        req_addr[d]     = 32'h10;
        req_valid[d]    = 1'b1;
        while (!req_ready[d] && w < 20) begin
            @(negedge clka);
            w++;
        end
        chk("rst_accept", 32'(req_ready[d]), 32'd1);
        @(negedge clka);
        req_valid[d] = 1'b0;
        @(negedge clka);
        chk("rst_wait_no_resp", 32'(resp_valid[d]), 32'd0);
        rst[d] = 1'b1;
        @(negedge clka);
        chk("rst_no_resp", 32'(resp_valid[d]), 32'd0);
        chk("rst_not_ready", 32'(req_ready[d]), 32'd0);
        rst[d] = 1'b0;
        @(negedge clka);
        chk("post_rst_ready", 32'(req_ready[d]), 32'd1);
        chk("post_rst_resp", 32'(resp_valid[d]), 32'd0);
        chk("post_rst_err_addr", err_addr[d], 32'd0);
    endtask

    task automatic run_dut(input int d);
        bit [31:0] g;
        xact(d, 1, 2, 0, 32'h10, 32'h80817F01, g);
        xact(d, 0, 0, 0, 32'h10, 0, g); chk("lb_10", g, 32'h00000001);
        xact(d, 0, 0, 0, 32'h12, 0, g); chk("lb_12", g, 32'hFFFFFF81);
        xact(d, 0, 0, 1, 32'h12, 0, g); chk("lbu_12", g, 32'h00000081);
        xact(d, 0, 1, 0, 32'h12, 0, g); chk("lh_12", g, 32'hFFFF8081);
        xact(d, 0, 1, 1, 32'h10, 0, g); chk("lhu_10", g, 32'h00007F01);
        xact(d, 0, 2, 0, 32'h10, 0, g); chk("lw_10", g, 32'h80817F01);
        xact(d, 1, 0, 0, 32'h13, 32'h000000AB, g);
        xact(d, 0, 2, 0, 32'h10, 0, g); chk("lw_10_sb", g, 32'hAB817F01);
        xact(d, 0, 2, 0, 32'h12, 0, g); chk("lw_12_err", g, 32'h0);
        xact(d, 0, 1, 0, 32'h11, 0, g); chk("lh_11_err", g, 32'h0);
        xact(d, 1, 2, 0, 32'h18, 32'h11223344, g);
        xact(d, 0, 2, 0, 32'h18, 0, g); chk("lw_18", g, 32'h11223344);
        reset_test(d);
        xact(d, 0, 2, 0, 32'h10, 0, g); chk("lw_after_rst", g, 32'hAB817F01);
        repeat (60)
            xact(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)), $urandom, g);
        req_valid[d] = 1'b0;
        @(negedge clka);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d]          = 1'b1;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_size[d]     = 2'd0;
            req_unsigned[d] = 1'b0;
            req_addr[d]     = '0;
            req_wdata[d]    = '0;
        end
        repeat (3) @(negedge clka);
        for (int d = 0; d < 2; d++) begin
            chk("reset_ready", 32'(req_ready[d]), 32'd0);
            chk("reset_resp_valid", 32'(resp_valid[d]), 32'd0);
            chk("reset_rdata", resp_rdata[d], 32'd0);
            chk("reset_addr_err", 32'(addr_err[d]), 32'd0);
            chk("reset_err_addr", err_addr[d], 32'd0);
            chk("reset_ram_ena", 32'(ram_ena[d]), 32'd0);
            chk("reset_ram_wea", 32'(ram_wea[d]), 32'd0);
            rst[d] = 1'b0;
        end
        @(negedge clka);
        for (int d = 0; d < 2; d++) run_dut(d);
        repeat (8) @(negedge clka);
        for (int d = 0; d < 2; d++)
            chk("resp_count", 32'(resp_seen[d]), 32'(resp_exp[d]));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
